// File: rtl/gemm_insn_dispatch.sv
// Instruction dispatcher for the gemm core: buffers host instructions in a FIFO,
// drops illegal ones and offers legal ones on the insn bus until the core reports done.
module gemm_insn_dispatch #(
  parameter int         INS_WIDTH   = 128,
  parameter int         UPC_WIDTH   = 13,
  parameter int         FIFO_DEPTH  = 8,
  parameter logic [2:0] OPCODE_GEMM = 3'd2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [INS_WIDTH-1:0]          s_insn_data,
  input  logic                          s_insn_valid,
  output logic                          s_insn_ready,
  output logic [INS_WIDTH-1:0]          insn,
  output logic                          insn_valid,
  input  logic                          insn_ready,
  input  logic                          gemm_done,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [15:0]                   drop_cnt,
  output logic [31:0]                   issued_cnt
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ITER_W  = 14;
  localparam int BGN_LSB = 8;
  localparam int END_LSB = BGN_LSB + UPC_WIDTH;
  localparam int IO_LSB  = END_LSB + UPC_WIDTH + 1;
  localparam int II_LSB  = IO_LSB + ITER_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [INS_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic                 push, pop, load, drop, fifo_empty;
  logic [INS_WIDTH-1:0] head;

  logic [2:0]           head_op;
  logic [UPC_WIDTH-1:0] head_bgn;
  logic [UPC_WIDTH:0]   head_end;
  logic [ITER_W-1:0]    head_iter_out, head_iter_in;
  logic                 head_legal;

  // FIFO
  assign s_insn_ready = (fifo_count < CNT_W'(FIFO_DEPTH));
  assign fifo_empty   = (fifo_count == '0);
  assign push         = s_insn_valid && s_insn_ready;
  assign head         = mem[rd_ptr];

  // NOTE: the storage array has no reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_insn_data;
  end

  // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Head decode; uop_end is one bit wider than uop_bgn, so compare zero-extended
  assign head_op       = head[2:0];
  assign head_bgn      = head[BGN_LSB +: UPC_WIDTH];
  assign head_end      = head[END_LSB +: UPC_WIDTH + 1];
  assign head_iter_out = head[IO_LSB +: ITER_W];
  assign head_iter_in  = head[II_LSB +: ITER_W];
  assign head_legal    = (head_op == OPCODE_GEMM) && (head_end > {1'b0, head_bgn}) &&
                         (head_iter_out != '0) && (head_iter_in != '0);

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!fifo_empty && head_legal) state_nxt = OFFER;
      OFFER:   if (insn_ready)                state_nxt = WAIT;
      WAIT:    if (gemm_done)                 state_nxt = IDLE;
      default:                                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    insn_valid = 1'b0;
    busy       = 1'b0;
    pop        = 1'b0;
    load       = 1'b0;
    drop       = 1'b0;
    case (state)
      IDLE: begin
        pop  = !fifo_empty;
        load = !fifo_empty && head_legal;
        drop = !fifo_empty && !head_legal;
      end
      OFFER: begin
        insn_valid = 1'b1;
        busy       = 1'b1;
      end
      WAIT:    busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // Held instruction and statistics
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      insn       <= '0;
      drop_cnt   <= '0;
      issued_cnt <= '0;
    end else begin
      if (load) insn <= head;
      if (drop && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
      if ((state == WAIT) && gemm_done) issued_cnt <= issued_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_gemm_insn_dispatch.sv
// Directed self-checking bench for gemm_insn_dispatch: latency, legality screening,
// FIFO full behaviour, spurious done pulses and mid-operation reset.
module tb_gemm_insn_dispatch;

  logic         clk;
  logic         rst;
  logic [127:0] s_insn_data;
  logic         s_insn_valid;
  logic         s_insn_ready;
  logic [127:0] insn;
  logic         insn_valid;
  logic         insn_ready;
  logic         gemm_done;
  logic         busy;
  logic [3:0]   fifo_count;
  logic [15:0]  drop_cnt;
  logic [31:0]  issued_cnt;

  int checks   = 0;
  int failures = 0;

  logic [127:0] stim  [16];
  logic [127:0] exp_q [16];
  logic [127:0] fill  [10];
  logic [127:0] w1;
  int busy_cycles, valid_cycles, first_valid;

  gemm_insn_dispatch dut (
    .clk          (clk),
    .rst          (rst),
    .s_insn_data  (s_insn_data),
    .s_insn_valid (s_insn_valid),
    .s_insn_ready (s_insn_ready),
    .insn         (insn),
    .insn_valid   (insn_valid),
    .insn_ready   (insn_ready),
    .gemm_done    (gemm_done),
    .busy         (busy),
    .fifo_count   (fifo_count),
    .drop_cnt     (drop_cnt),
    .issued_cnt   (issued_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, want);
    end
  endtask

  function automatic logic [127:0] mk(input logic [2:0] op, input logic [12:0] bgn,
                                      input logic [13:0] uend, input logic [13:0] iout,
                                      input logic [13:0] iin, input logic [31:0] tag);
    logic [127:0] w;
    w          = '0;
    w[2:0]     = op;
    w[20:8]    = bgn;
    w[34:21]   = uend;
    w[48:35]   = iout;
    w[62:49]   = iin;
    w[95:64]   = ~tag;
    w[127:96]  = tag;
    return w;
  endfunction

  // Pushes stim[0..n_in-1], completes every WAIT with a done pulse and compares each
  // offered instruction with exp_q in order. Requires insn_ready high.
  task automatic run_stream(input string name, input int n_in, input int n_out, input int budget);
    int in_idx  = 0;
    int out_idx = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (insn_valid) begin
        if (out_idx < n_out) check({name, "_insn"}, insn, exp_q[out_idx]);
        else                 check({name, "_extra_valid"}, 128'(insn_valid), 128'(0));
        out_idx++;
      end
      gemm_done = busy && !insn_valid;
      if (in_idx < n_in) begin
        s_insn_valid = 1'b1;
        s_insn_data  = stim[in_idx];
        if (s_insn_ready) in_idx++;
      end else begin
        s_insn_valid = 1'b0;
      end
    end
    s_insn_valid = 1'b0;
    gemm_done    = 1'b0;
    check({name, "_dispatched"}, 128'(out_idx), 128'(n_out));
    check({name, "_idle_at_end"}, 128'(busy), 128'(0));
  endtask

  initial begin
    rst          = 1'b0;
    s_insn_data  = '0;
    s_insn_valid = 1'b0;
    insn_ready   = 1'b1;
    gemm_done    = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_insn",       insn,              128'(0));
    check("rst_insn_valid", 128'(insn_valid),  128'(0));
    check("rst_busy",       128'(busy),        128'(0));
    check("rst_fifo_count", 128'(fifo_count),  128'(0));
    check("rst_drop_cnt",   128'(drop_cnt),    128'(0));
    check("rst_issued_cnt", 128'(issued_cnt),  128'(0));
    rst = 1'b1;
    @(negedge clk);
    check("rst_ready_after_release", 128'(s_insn_ready), 128'(1));

    // Single legal instruction, core ready, done pulsed in WAIT
    w1 = mk(3'd2, 13'd1, 14'd2, 14'd16, 14'd1, 32'hA001);
    @(negedge clk);
    s_insn_valid = 1'b1;
    s_insn_data  = w1;
    busy_cycles  = 0;
    valid_cycles = 0;
    first_valid  = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      s_insn_valid = 1'b0;
      if (k == 1) begin
        check("t1_count_after_push", 128'(fifo_count), 128'(1));
        check("t1_no_early_valid",   128'(insn_valid), 128'(0));
      end
      if (busy) busy_cycles++;
      if (insn_valid) begin
        valid_cycles++;
        if (first_valid < 0) first_valid = k;
      end
      gemm_done = (k == 8);
    end
    gemm_done = 1'b0;
    check("t1_valid_latency", 128'(first_valid),  128'(2));
    check("t1_valid_cycles",  128'(valid_cycles), 128'(1));
    check("t1_busy_cycles",   128'(busy_cycles),  128'(7));
    check("t1_insn_held",     insn,               w1);
    check("t1_issued",        128'(issued_cnt),   128'(1));
    check("t1_fifo_empty",    128'(fifo_count),   128'(0));

    // Bad opcode and empty uop range are dropped; only the legal word is offered
    stim[0]  = mk(3'd3, 13'd1, 14'd2, 14'd1, 14'd1, 32'hB001);
    stim[1]  = mk(3'd2, 13'd4, 14'd4, 14'd1, 14'd1, 32'hB002);
    stim[2]  = mk(3'd2, 13'd0, 14'd5, 14'd3, 14'd3, 32'hB003);
    exp_q[0] = stim[2];
    run_stream("t2", 3, 1, 20);
    check("t2_drop_cnt", 128'(drop_cnt),   128'(2));
    check("t2_issued",   128'(issued_cnt), 128'(2));

    // Zero iteration counts and the 14-bit uop boundary
    stim[0]  = mk(3'd2, 13'd1,    14'd2,    14'd0, 14'd1, 32'hC001);
    stim[1]  = mk(3'd2, 13'd1,    14'd2,    14'd1, 14'd0, 32'hC002);
    stim[2]  = mk(3'd2, 13'h1FFF, 14'h1FFF, 14'd1, 14'd1, 32'hC003);
    stim[3]  = mk(3'd2, 13'h1FFF, 14'h2000, 14'd1, 14'd1, 32'hC004);
    exp_q[0] = stim[3];
    run_stream("t2b", 4, 1, 25);
    check("t2b_drop_cnt", 128'(drop_cnt),   128'(5));
    check("t2b_issued",   128'(issued_cnt), 128'(3));

    // Fill with core stalled; 10th push refused
    insn_ready = 1'b0;
    for (int k = 0; k < 10; k++) fill[k] = mk(3'd2, 13'(k), 14'(k + 10), 14'd1, 14'd2, 32'hD000 + k);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 8) begin
        check("t3_count_7",   128'(fifo_count),   128'(7));
        check("t3_ready_at7", 128'(s_insn_ready), 128'(1));
      end
      if (k == 9) begin
        check("t3_count_8",   128'(fifo_count),   128'(8));
        check("t3_ready_at8", 128'(s_insn_ready), 128'(0));
      end
      s_insn_valid = 1'b1;
      s_insn_data  = fill[k];
    end
    @(negedge clk);
    check("t3_10th_refused",  128'(fifo_count), 128'(8));
    check("t3_offer_valid",   128'(insn_valid), 128'(1));
    check("t3_offer_insn",    insn,             fill[0]);
    insn_ready = 1'b1;
    @(negedge clk);
    check("t4_wait_busy",  128'(busy),       128'(1));
    check("t4_wait_count", 128'(fifo_count), 128'(8));
    gemm_done = 1'b1;
    @(negedge clk);
    gemm_done = 1'b0;
    check("t4_idle",        128'(busy),       128'(0));
    check("t4_issued",      128'(issued_cnt), 128'(4));
    check("t4_still_full",  128'(fifo_count), 128'(8));
    @(negedge clk);
    check("t4_pop_push_refused", 128'(fifo_count), 128'(7));
    check("t4_next_insn",        insn,             fill[1]);
    s_insn_valid = 1'b0;
    for (int k = 0; k < 7; k++) exp_q[k] = fill[k + 2];
    run_stream("t4_drain", 0, 7, 40);
    check("t4_drained",      128'(fifo_count), 128'(0));
    check("t4_issued_total", 128'(issued_cnt), 128'(12));

    // Done pulses outside WAIT are ignored
    @(negedge clk);
    gemm_done = 1'b1;
    @(negedge clk);
    gemm_done = 1'b0;
    check("t5_idle_done_busy",   128'(busy),       128'(0));
    check("t5_idle_done_issued", 128'(issued_cnt), 128'(12));
    insn_ready   = 1'b0;
    s_insn_valid = 1'b1;
    s_insn_data  = mk(3'd2, 13'd2, 14'd3, 14'd1, 14'd1, 32'hE001);
    @(negedge clk);
    s_insn_valid = 1'b0;
    @(negedge clk);
    check("t5_in_offer", 128'(insn_valid), 128'(1));
    gemm_done = 1'b1;
    @(negedge clk);
    gemm_done = 1'b0;
    check("t5_offer_done_valid",  128'(insn_valid), 128'(1));
    check("t5_offer_done_issued", 128'(issued_cnt), 128'(12));
    insn_ready = 1'b1;
    @(negedge clk);
    insn_ready = 1'b0;
    check("t6_in_wait", 128'(busy & ~insn_valid), 128'(1));

    // Queue 3 behind the in-flight instruction, then reset mid-cycle
    for (int k = 0; k < 3; k++) begin
      s_insn_valid = 1'b1;
      s_insn_data  = mk(3'd2, 13'd1, 14'd9, 14'd1, 14'd1, 32'hE100 + k);
      @(negedge clk);
    end
    s_insn_valid = 1'b0;
    check("t6_queued", 128'(fifo_count), 128'(3));
    #2 rst = 1'b0;
    #1;
    check("t6_rst_insn",       insn,             128'(0));
    check("t6_rst_valid",      128'(insn_valid), 128'(0));
    check("t6_rst_busy",       128'(busy),       128'(0));
    check("t6_rst_count",      128'(fifo_count), 128'(0));
    check("t6_rst_drop_cnt",   128'(drop_cnt),   128'(0));
    check("t6_rst_issued_cnt", 128'(issued_cnt), 128'(0));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6_ready_after", 128'(s_insn_ready), 128'(1));
    insn_ready = 1'b1;
    stim[0]  = mk(3'd2, 13'd7, 14'd8, 14'd4, 14'd4, 32'hF001);
    exp_q[0] = stim[0];
    run_stream("t6_post", 1, 1, 15);
    check("t6_post_issued", 128'(issued_cnt), 128'(1));
    check("t6_post_drop",   128'(drop_cnt),   128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/gemm_insn_dispatch.md
# gemm_insn_dispatch

Instruction dispatcher sitting in front of the `gemm` core. It accepts 128-bit GEMM instructions from the host/fetch side, buffers them in a small FIFO and screens them for legality. It presents one instruction at a time on the `insn` bus the core consumes, holding the bus stable until the core signals completion. It is the producer end of the `insn` interface; the core is the consumer.

## Interface
- `INS_WIDTH`, 128: instruction width; field layout as consumed by `gemm`.
- `UPC_WIDTH`, 13: width of the `uop_bgn` field.
- `FIFO_DEPTH`, 8: instruction FIFO entries; power of two, ≥2.
- `OPCODE_GEMM`, 3'd2: opcode value that is dispatched.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-low reset.
- `s_insn_data`  in  INS_WIDTH  instruction from host.
- `s_insn_valid`  in  1  host offers `s_insn_data`.
- `s_insn_ready`  out  1  FIFO can accept; a push occurs when valid&&ready.
- `insn`  out  INS_WIDTH  instruction to `gemm`; registered.
- `insn_valid`  out  1  `insn` newly offered.
- `insn_ready`  in  1  core accepts `insn`.
- `gemm_done`  in  1  one-cycle pulse: core finished the current instruction.
- `busy`  out  1  high in OFFER or WAIT.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- `drop_cnt`  out  16  rejected instructions, saturating.
- `issued_cnt`  out  32  completed instructions, wrapping.

## Operation
- Decoded fields of the FIFO head: opcode [2:0], uop_bgn [20:8], uop_end [34:21], iter_out [48:35], iter_in [62:49].
- Legality: opcode==OPCODE_GEMM, uop_end > {1'b0,uop_bgn} (unsigned, 14-bit compare), iter_out≠0, iter_in≠0.
- FIFO:
  - `s_insn_ready` = (fifo_count < FIFO_DEPTH), combinational from count only.
  - A push and a pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - When full, a push is refused even if a pop occurs that cycle.
- FSM, 3 states:
  - IDLE
    - FIFO empty: stay.
    - Head illegal: pop, drop_cnt+1 (saturate at 16'hFFFF), stay in IDLE. Sustained rate is one drop per cycle.
    - Head legal: pop, load `insn` ← head, go to OFFER.
  - OFFER: `insn_valid`=1; on `insn_ready`, go to WAIT.
  - WAIT: `insn_valid`=0, `insn` held; on `gemm_done`, issued_cnt+1, go to IDLE.
- `gemm_done` is ignored in IDLE and OFFER.
- `insn` changes only on a legal load in IDLE; otherwise it retains its last value.
- `busy` = (state≠IDLE).

## Timing
- Reset (rst=0, asynchronous): state=IDLE, FIFO empty, `insn`=0, `insn_valid`=0, `busy`=0, `fifo_count`=0, `drop_cnt`=0, `issued_cnt`=0, `s_insn_ready`=1 once reset is released.
- Reset asserted mid-operation discards all FIFO contents and any in-flight instruction. No `gemm_done` is expected afterwards.
- Latency, empty FIFO with FSM in IDLE:
  - Push accepted at edge t.
  - Head visible after t; popped at edge t+1.
  - `insn`/`insn_valid` valid from edge t+1 (high during cycle t+1..).
- `insn_valid` is asserted from the OFFER entry edge through the edge at which `insn_ready` is sampled high. If `insn_ready` is already high at entry, `insn_valid` lasts exactly one cycle.
- Throughput: a new legal instruction is loaded no earlier than the edge after the `gemm_done` edge. WAIT→IDLE costs one cycle.
- `fifo_count` reflects pushes and pops on the edge they occur.

## Test plan
- Single legal instruction (opcode 2, uop_bgn 1, uop_end 2, iter_out 16, iter_in 1, factors 1/0/1/0/0/0) pushed; `insn_ready` tied high; `gemm_done` pulsed 5 cycles later -> `insn` matches the pushed word, `insn_valid` high for 1 cycle, busy high for 7 cycles, issued_cnt=1.
- Push an opcode-3 instruction, then a uop_end=uop_bgn=4 instruction, then a legal one -> drop_cnt=2, only the legal word appears on `insn`, with no `insn_valid` for the rejected entries.
- Push 9 legal instructions back-to-back with core stalled (`insn_ready`=0) -> `fifo_count` reaches 7 (one held in OFFER) then 8, `s_insn_ready` low at 8, and the 10th push is refused.
- Full FIFO with simultaneous pop and push attempt -> push refused, count drops by 1.
- `gemm_done` pulse during OFFER and during IDLE -> no state change, issued_cnt unchanged.
- Assert rst mid-WAIT with 3 entries queued -> all outputs return to reset values immediately, `fifo_count`=0, and a later push dispatches normally.
